// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder for KEY/SW inputs and HEX/LEDR outputs.
// Define IO_DEBOUNCE_EN to enable the per-group input debounce counters.
module io_bus_responder #(
  parameter int                       DBITS           = 32,
  parameter logic [DBITS-1:0]         ADDR_HEX        = 32'hF000_0000,
  parameter logic [DBITS-1:0]         ADDR_LEDR       = 32'hF000_0004,
  parameter logic [DBITS-1:0]         ADDR_KEY        = 32'hF000_0010,
  parameter logic [DBITS-1:0]         ADDR_SW         = 32'hF000_0014,
  parameter logic [DBITS-1:0]         ADDR_KCTRL      = 32'hF000_0110,
  parameter logic [DBITS-1:0]         ADDR_SCTRL      = 32'hF000_0114,
  parameter int                       DEBOUNCE_BITS   = 20,
  parameter logic [DEBOUNCE_BITS-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DBITS-1:0] wr_data,
  output logic [DBITS-1:0] rd_data,
  output logic             is_io,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  output logic [15:0]      hex_out,
  output logic [9:0]       ledr_out
);

  logic [3:0]  key_sync1_q, key_sync1_d;
  logic [9:0]  sw_sync1_q, sw_sync1_d;
  logic [3:0]  key_stable_q, key_stable_d;
  logic [9:0]  sw_stable_q, sw_stable_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;
  logic        k_rdy_q, k_rdy_d, k_ovr_q, k_ovr_d, k_ie_q, k_ie_d;
  logic        s_rdy_q, s_rdy_d, s_ovr_q, s_ovr_d, s_ie_q, s_ie_d;
  logic        key_evt, sw_evt;
  logic        k_rdy_clr, k_ovr_clr, s_rdy_clr, s_ovr_clr;
  logic        wr_kctrl, wr_sctrl;
  logic        unused_ok;

`ifdef IO_DEBOUNCE_EN
  localparam logic [DEBOUNCE_BITS-1:0] DB_LAST =
    DEBOUNCE_CYCLES - {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic [3:0]               key_sync2_q, key_sync2_d;
  logic [9:0]               sw_sync2_q, sw_sync2_d;
  logic [3:0]               key_sync;
  logic [DEBOUNCE_BITS-1:0] key_cnt_q, key_cnt_d, sw_cnt_q, sw_cnt_d;

  always_comb begin
    key_sync2_d  = key_sync1_q;
    sw_sync2_d   = sw_sync1_q;
    key_sync     = ~key_sync2_q;
    key_stable_d = key_stable_q;
    sw_stable_d  = sw_stable_q;
    key_cnt_d    = key_cnt_q;
    sw_cnt_d     = sw_cnt_q;
    if (key_sync == key_stable_q) begin
      key_cnt_d = '0;
    end else if (key_cnt_q == DB_LAST) begin
      key_stable_d = key_sync;
      key_cnt_d    = '0;
    end else begin
      key_cnt_d = key_cnt_q + 1'b1;
    end
    if (sw_sync2_q == sw_stable_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == DB_LAST) begin
      sw_stable_d = sw_sync2_q;
      sw_cnt_d    = '0;
    end else begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync2_q <= 4'hF;
      sw_sync2_q  <= '0;
      key_cnt_q   <= '0;
      sw_cnt_q    <= '0;
    end else begin
      key_sync2_q <= key_sync2_d;
      sw_sync2_q  <= sw_sync2_d;
      key_cnt_q   <= key_cnt_d;
      sw_cnt_q    <= sw_cnt_d;
    end
  end

  assign unused_ok = ^wr_data[DBITS-1:16];
`else
  // Without debounce the stable register doubles as the second sync stage,
  // giving the two-cycle acceptance latency.
  always_comb begin
    key_stable_d = ~key_sync1_q;
    sw_stable_d  = sw_sync1_q;
  end

  assign unused_ok = ^{wr_data[DBITS-1:16], DEBOUNCE_CYCLES};
`endif

  assign key_evt = (key_stable_d != key_stable_q);
  assign sw_evt  = (sw_stable_d != sw_stable_q);
  assign is_io   = (addr[DBITS-1:DBITS-4] == 4'hF);

  assign wr_kctrl  = wr_en && (addr == ADDR_KCTRL);
  assign wr_sctrl  = wr_en && (addr == ADDR_SCTRL);
  assign k_rdy_clr = (wr_kctrl && !wr_data[0]) || (rd_en && (addr == ADDR_KEY));
  assign k_ovr_clr = wr_kctrl && !wr_data[2];
  assign s_rdy_clr = (wr_sctrl && !wr_data[0]) || (rd_en && (addr == ADDR_SW));
  assign s_ovr_clr = wr_sctrl && !wr_data[2];

  always_comb begin
    key_sync1_d = key_in;
    sw_sync1_d  = sw_in;
    hex_d       = hex_q;
    ledr_d      = ledr_q;
    if (wr_en && (addr == ADDR_HEX))  hex_d  = wr_data[15:0];
    if (wr_en && (addr == ADDR_LEDR)) ledr_d = wr_data[9:0];
    k_ie_d  = wr_kctrl ? wr_data[4] : k_ie_q;
    s_ie_d  = wr_sctrl ? wr_data[4] : s_ie_q;
    // An event beats a same-cycle clear of ready; overrun needs ready to survive.
    k_rdy_d = key_evt || (k_rdy_q && !k_rdy_clr);
    k_ovr_d = (k_ovr_q && !k_ovr_clr) || (key_evt && k_rdy_q && !k_rdy_clr);
    s_rdy_d = sw_evt || (s_rdy_q && !s_rdy_clr);
    s_ovr_d = (s_ovr_q && !s_ovr_clr) || (sw_evt && s_rdy_q && !s_rdy_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync1_q  <= 4'hF;
      sw_sync1_q   <= '0;
      key_stable_q <= '0;
      sw_stable_q  <= '0;
      hex_q        <= '0;
      ledr_q       <= '0;
      k_rdy_q      <= 1'b0;
      k_ovr_q      <= 1'b0;
      k_ie_q       <= 1'b0;
      s_rdy_q      <= 1'b0;
      s_ovr_q      <= 1'b0;
      s_ie_q       <= 1'b0;
    end else begin
      key_sync1_q  <= key_sync1_d;
      sw_sync1_q   <= sw_sync1_d;
      key_stable_q <= key_stable_d;
      sw_stable_q  <= sw_stable_d;
      hex_q        <= hex_d;
      ledr_q       <= ledr_d;
      k_rdy_q      <= k_rdy_d;
      k_ovr_q      <= k_ovr_d;
      k_ie_q       <= k_ie_d;
      s_rdy_q      <= s_rdy_d;
      s_ovr_q      <= s_ovr_d;
      s_ie_q       <= s_ie_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_HEX:   rd_data[15:0] = hex_q;
      ADDR_LEDR:  rd_data[9:0]  = ledr_q;
      ADDR_KEY:   rd_data[3:0]  = key_stable_q;
      ADDR_SW:    rd_data[9:0]  = sw_stable_q;
      ADDR_KCTRL: rd_data[4:0]  = {k_ie_q, 1'b0, k_ovr_q, 1'b0, k_rdy_q};
      ADDR_SCTRL: rd_data[4:0]  = {s_ie_q, 1'b0, s_ovr_q, 1'b0, s_rdy_q};
      default:    rd_data       = '0;
    endcase
  end

  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder on the CPU data bus.
- Answers loads and stores to the KEY, SW, HEX and LEDR addresses (plus two status/control registers).
- Synchronizes and debounces the board inputs and raises sticky change/overrun flags.
- Drives the registered HEX value and LEDR outputs.
- Sits beside data memory; the data-path mux selects rd_data whenever is_io is high.

Parameters:
- DBITS, 32, bus data width
- ADDR_HEX, 32'hF0000000, HEX data register (RW)
- ADDR_LEDR, 32'hF0000004, LEDR data register (RW)
- ADDR_KEY, 32'hF0000010, KEY data (RO)
- ADDR_SW, 32'hF0000014, SW data (RO)
- ADDR_KCTRL, 32'hF0000110, KEY status/control
- ADDR_SCTRL, 32'hF0000114, SW status/control
- DEBOUNCE_BITS, 20, debounce counter width
- DEBOUNCE_CYCLES, 20'd500000, cycles an input must be stable before acceptance (10 ms at 50 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  DBITS  bus address
- wr_en  in  1  store strobe, sampled at posedge clk
- rd_en  in  1  load strobe, sampled at posedge clk; used only for read side effects
- wr_data  in  DBITS  store data
- rd_data  out  DBITS  load data, combinational from addr and registered state
- is_io  out  1  high when addr[31:28]==4'hF (combinational)
- key_in  in  4  raw KEY pins, active-low
- sw_in  in  10  raw SW pins
- hex_out  out  16  HEX register: four nibbles for the 7-seg decoders
- ledr_out  out  10  LEDR register

Behaviour:
- Reset values:
  - hex_out=0, ledr_out=0.
  - KEY synchronizer flops=4'hF, key_stable=0, sw_stable=0, counters=0.
  - All status bits=0.
- Synchronizers: 2-flop per bit on key_in and sw_in. The KEY path is inverted after synchronization, so a pressed key reads 1.
- Debounce (IO_DEBOUNCE_EN), one counter per group, compared as whole vectors:
  - sync==stable: counter<=0.
  - Otherwise counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and the vectors still differ: stable<=sync, counter<=0.
  - Acceptance latency from a clean input edge is 2+DEBOUNCE_CYCLES cycles.
  - Any mid-count bounce back to the stable value restarts the count.
- Change event: asserted for one cycle when a group's stable value is updated.
- Status register layout (KCTRL / SCTRL): bit0 ready, bit2 overrun, bit4 ie (RW, no internal effect, reserved for interrupt logic). Other bits read 0.
- Per-cycle status update, in this priority order:
  1. Clear sources:
     - Store to xCTRL with wr_data[0]==0 clears ready.
     - Store to xCTRL with wr_data[2]==0 clears overrun.
     - Writing 1 to ready or overrun has no effect.
     - A load (rd_en) of ADDR_KEY / ADDR_SW clears that group's ready.
  2. Change event:
     - Sets ready.
     - Also sets overrun if ready was 1 and is not being cleared this same cycle.
     - An event therefore always wins over a simultaneous clear of ready.
- Stores:
  - ADDR_HEX: hex_out<=wr_data[15:0].
  - ADDR_LEDR: ledr_out<=wr_data[9:0].
  - xCTRL: ie<=wr_data[4].
  - Stores to KEY/SW data and to unmapped addresses are ignored.
  - Store data is visible one cycle after the edge.
- Loads (zero-extended to DBITS):
  - HEX returns hex_out.
  - LEDR returns ledr_out.
  - KEY returns key_stable.
  - SW returns sw_stable.
  - xCTRL returns the status word.
  - Unmapped addresses return 0.
- wr_en and rd_en both high on the same address: store effects and read side effect both apply.
- Reset mid-debounce or mid-operation: everything returns to reset values immediately (asynchronous); no pending event survives.

Optional Feature:
- Macro: IO_DEBOUNCE_EN.
- Defined: debounce counters as described.
- Undefined:
  - Counters are removed; stable<=sync every cycle.
  - A change event fires on any synchronized change; latency is 2 cycles.
  - DEBOUNCE_BITS and DEBOUNCE_CYCLES are unused.

Test Plan:
- Reset release: hex_out=0, ledr_out=0. Load of ADDR_KEY, ADDR_SW, ADDR_KCTRL each returns 0. is_io=1 for addr F0000014, 0 for addr 00000100.
- Store wr_data=32'hDEADBEEF to ADDR_HEX → hex_out=16'hBEEF next cycle. Store 32'hFFFFFFFF to ADDR_LEDR → ledr_out=10'h3FF. Store to ADDR_SW → SW readback unchanged.
- Debounce (DEBOUNCE_CYCLES=4, macro defined):
  - sw_in 0→10'h005 → SW reads 0x005 and SCTRL reads 0x1 exactly 6 cycles later.
  - A glitch of 3 cycles produces no change.
- KEY press key_in=4'b1110 held → KEY reads 0x1, KCTRL=0x1. A load with rd_en of ADDR_KEY clears KCTRL to 0x0.
- Overrun: two accepted SW changes with no clear → SCTRL=0x5. Store 0 to ADDR_SCTRL → 0x0.
- A clear store coinciding with a change event → SCTRL=0x1, overrun not set.
- Assert reset mid-debounce (counter=2) → counter, stable and status are 0; after release the input needs the full count again.
